// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the multiply/divide unit.
package mips_pkg;

    // Encoding of the MDOperation field driven by the execute stage.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Sequencer states of the multiply/divide unit.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    // One iteration per operand bit.
    localparam int MD_ITERATIONS = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Sequential 32-bit MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO
// registers. Operands are reduced to magnitudes, iterated one bit per cycle,
// and the signs are reapplied in a final fix-up cycle.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       MDOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WriteHI,
    input  logic             WriteLO,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(MD_ITERATIONS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MD_ITERATIONS - 1);

    // Absolute value for signed ops; 0x80000000 maps to 2^31, so the result
    // carries one extra bit.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
        logic [WIDTH-1:0] neg_v;
        neg_v = ~v + WIDTH'(1);
        return (is_signed && v[WIDTH-1]) ? {1'b0, neg_v} : {1'b0, v};
    endfunction

    // Conditional negate of a {hi, lo} pair. With 'joined' set the pair is one
    // 64-bit product; otherwise hi (remainder) and lo (quotient) are negated
    // independently. For the joined case -{h,l} = {~h + (l == 0), -l}.
    function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v,
                                               input logic          neg_hi,
                                               input logic          neg_lo,
                                               input logic          joined);
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             inc;
        hi  = v[DW-1:WIDTH];
        lo  = v[WIDTH-1:0];
        inc = joined ? (lo == '0) : 1'b1;
        if (neg_lo) lo = ~lo + WIDTH'(1);
        if (neg_hi) hi = ~hi + {{(WIDTH-1){1'b0}}, inc};
        return {hi, lo};
    endfunction

    md_state_e        r_state;
    md_state_e        w_state_next;
    logic [CNT_W-1:0] r_count;
    md_op_e           r_op;
    logic [WIDTH:0]   r_a_mag;
    logic [WIDTH:0]   r_b_mag;
    logic [WIDTH-1:0] r_a_raw;
    logic             r_neg_hi;
    logic             r_neg_lo;
    logic             r_div_zero;
    logic [DW-1:0]    r_acc;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic             w_signed_op;
    logic             w_start_mul;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH:0]   w_a_mag;
    logic [WIDTH:0]   w_b_mag;
    logic             w_is_mul;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_ok;
    logic [DW-1:0]    w_step;
    logic [DW-1:0]    w_fixed;

    assign w_signed_op = (MDOperation == MD_MULT) || (MDOperation == MD_DIV);
    assign w_start_mul = (MDOperation == MD_MULT) || (MDOperation == MD_MULTU);
    assign w_sign_a    = w_signed_op & A[WIDTH-1];
    assign w_sign_b    = w_signed_op & B[WIDTH-1];
    assign w_a_mag     = magnitude(A, w_signed_op);
    assign w_b_mag     = magnitude(B, w_signed_op);
    assign w_is_mul    = (r_op == MD_MULT) || (r_op == MD_MULTU);
    assign w_fixed     = cond_neg(r_acc, r_neg_hi, r_neg_lo, w_is_mul);

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[DW-1:WIDTH]} + (r_acc[0] ? r_a_mag : '0);
        w_div_shift = r_acc[DW-1:WIDTH-1];
        w_div_diff  = {1'b0, w_div_shift} - {1'b0, r_b_mag};
        // A successful subtraction always leaves a value below the divisor,
        // so bit WIDTH is clear exactly when the trial step is accepted.
        w_div_ok    = ~(w_div_diff[WIDTH+1] | w_div_diff[WIDTH]);
        if (w_is_mul) begin
            w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
        end else begin
            w_step = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_div_ok};
        end
    end

    // Next-state logic of the IDLE -> CALC -> FIX sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_state_next = CALC;
            CALC:    if (r_count == LAST_ITER) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Operand capture, iteration datapath, HI/LO and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_op       <= MD_MULT;
            r_a_mag    <= '0;
            r_b_mag    <= '0;
            r_a_raw    <= '0;
            r_neg_hi   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_div_zero <= 1'b0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_busy <= (w_state_next != IDLE);
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_op       <= md_op_e'(MDOperation);
                        r_a_mag    <= w_a_mag;
                        r_b_mag    <= w_b_mag;
                        r_a_raw    <= A;
                        r_neg_lo   <= w_sign_a ^ w_sign_b;
                        r_neg_hi   <= w_start_mul ? (w_sign_a ^ w_sign_b) : w_sign_a;
                        r_div_zero <= ~w_start_mul && (B == '0);
                        r_count    <= '0;
                        // Multiplier or dividend sits in the low half of the accumulator.
                        r_acc      <= {{WIDTH{1'b0}},
                                       (w_start_mul ? w_b_mag[WIDTH-1:0] : w_a_mag[WIDTH-1:0])};
                    end else begin
                        if (WriteHI) r_hi <= A;
                        if (WriteLO) r_lo <= A;
                    end
                end
                CALC: begin
                    r_count <= r_count + CNT_W'(1);
                    r_acc   <= w_step;
                end
                FIX: begin
                    if (r_div_zero) begin
                        r_hi  <= r_a_raw;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else begin
                        r_hi <= w_fixed[DW-1:WIDTH];
                        r_lo <= w_fixed[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign HI        = r_hi;
    assign LO        = r_lo;

endmodule
